// File: rtl/dff_ring_recirc.sv
// dff_ring_recirc: recirculating DFF ring. A frame of up to DEPTH words is
// loaded through stage 0, then rotated indefinitely from the last stage back
// into stage 0. Output is masked while loading and for one hand-over cycle.
// The build macro DFF_RING_CLR_EN adds a synchronous clear input (i_CLR).
module dff_ring_recirc #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int IW    = $clog2(DEPTH),
  localparam int FW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             i_EN,
  input  logic             i_WR,
  input  logic [WIDTH-1:0] i_data,
`ifdef DFF_RING_CLR_EN
  input  logic             i_CLR,
`endif
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_sop,
  output logic [IW-1:0]    o_idx,
  output logic             o_full,
  output logic [FW-1:0]    o_fill
);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [FW-1:0]    fill;
  logic [IW-1:0]    pos;
  logic             wr_d;
  logic             clr;

`ifdef DFF_RING_CLR_EN
  assign clr = i_CLR;
`else
  assign clr = 1'b0;
`endif

  // Ring stages: load or recirculate into stage 0, shift the rest along.
  // Clear wins over enable so a stalled ring can still be flushed.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (i_EN) begin
      stage[0] <= i_WR ? i_data : stage[DEPTH-1];
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  // Fill counter, output word index and hand-over flag.
  // A write restarts the index because the oldest retained word becomes idx 0.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      fill <= '0;
      pos  <= '0;
      wr_d <= 1'b0;
    end else if (clr) begin
      fill <= '0;
      pos  <= '0;
      wr_d <= 1'b0;
    end else if (i_EN) begin
      if (i_WR) begin
        if (fill != FW'(DEPTH)) fill <= fill + 1'b1;
        pos  <= '0;
        wr_d <= 1'b1;
      end else begin
        pos  <= (pos == IW'(DEPTH - 1)) ? '0 : pos + 1'b1;
        wr_d <= 1'b0;
      end
    end
  end

  // Output qualification: only a complete frame, never while writing, and not
  // in the hand-over cycle right after the last write.
  always_comb begin
    o_full  = (fill == FW'(DEPTH));
    o_valid = ~i_WR & ~wr_d & o_full;
    o_data  = o_valid ? stage[DEPTH-1] : '0;
    o_idx   = pos;
    o_sop   = o_valid & (pos == '0);
    o_fill  = fill;
  end

endmodule

// File: tb/tb_dff_ring_recirc.sv
// Directed testbench for dff_ring_recirc (WIDTH=8, DEPTH=4). Expected output
// records are queued as each step is driven and popped when the DUT output is
// sampled, just before the next rising edge.
module tb_dff_ring_recirc;

  logic       clk;
  logic       RST_n;
  logic       i_EN;
  logic       i_WR;
  logic [7:0] i_data;
`ifdef DFF_RING_CLR_EN
  logic       i_CLR;
`endif
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_sop;
  logic [1:0] o_idx;
  logic       o_full;
  logic [2:0] o_fill;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [1:0] idx;
    logic       sop;
    logic [2:0] fill;
    logic       full;
  } exp_t;

  exp_t sb[$];

  dff_ring_recirc #(.WIDTH(8), .DEPTH(4)) dut (
    .clk     (clk),
    .RST_n   (RST_n),
    .i_EN    (i_EN),
    .i_WR    (i_WR),
    .i_data  (i_data),
`ifdef DFF_RING_CLR_EN
    .i_CLR   (i_CLR),
`endif
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_sop   (o_sop),
    .o_idx   (o_idx),
    .o_full  (o_full),
    .o_fill  (o_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic ev, input logic [7:0] ed, input logic [1:0] ei,
                      input logic es, input logic [2:0] ef);
    exp_t e;
    e.valid = ev; e.data = ed; e.idx = ei; e.sop = es; e.fill = ef;
    e.full  = (ef == 3'd4);
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    total++;
    assert (o_valid === e.valid) else begin
      bad++; $error("FAIL %s valid: got %b want %b", tag, o_valid, e.valid);
    end
    total++;
    assert (o_data === e.data) else begin
      bad++; $error("FAIL %s data: got %h want %h", tag, o_data, e.data);
    end
    total++;
    assert (o_idx === e.idx) else begin
      bad++; $error("FAIL %s idx: got %0d want %0d", tag, o_idx, e.idx);
    end
    total++;
    assert (o_sop === e.sop) else begin
      bad++; $error("FAIL %s sop: got %b want %b", tag, o_sop, e.sop);
    end
    total++;
    assert (o_fill === e.fill) else begin
      bad++; $error("FAIL %s fill: got %0d want %0d", tag, o_fill, e.fill);
    end
    total++;
    assert (o_full === e.full) else begin
      bad++; $error("FAIL %s full: got %b want %b", tag, o_full, e.full);
    end
    $display("%s: valid=%b data=%h idx=%0d sop=%b fill=%0d full=%b",
             tag, o_valid, o_data, o_idx, o_sop, o_fill, o_full);
  endtask

  // One cycle: drive at the falling edge, queue expectation, sample 1 ns later.
  task automatic cyc(input logic en, input logic wr, input logic [7:0] d,
                     input logic ev, input logic [7:0] ed, input logic [1:0] ei,
                     input logic es, input logic [2:0] ef, input string tag);
    @(negedge clk);
    i_EN = en; i_WR = wr; i_data = d;
    push(ev, ed, ei, es, ef);
    #1;
    check(tag);
  endtask

  initial begin
    logic [7:0] w4 [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] t2d [8] = '{8'h00, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] w6 [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] t4d [6] = '{8'h00, 8'h44, 8'h55, 8'h66, 8'h33, 8'h44};

    RST_n = 1'b0; i_EN = 1'b0; i_WR = 1'b0; i_data = 8'h00;
`ifdef DFF_RING_CLR_EN
    i_CLR = 1'b0;
`endif
    // Test 1: reset state, then load a full frame
    #3;
    push(1'b0, 8'h00, 2'd0, 1'b0, 3'd0);
    check("reset");
    @(negedge clk);
    RST_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, w4[i], 1'b0, 8'h00, 2'd0, 1'b0, 3'(i), $sformatf("load%0d", i));

    // Test 2: recirculate eight cycles, hand-over first
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 8'h00, (i != 0), t2d[i], 2'(i % 4), (i == 4), 3'd4,
          $sformatf("rot%0d", i));

    // Test 3: stall mid-rotation (write ignored while stalled), then resume
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 2'd0, 1'b1, 3'd4, "pre_stall0");
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 2'd1, 1'b0, 3'd4, "pre_stall1");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 2'd2, 1'b0, 3'd4, $sformatf("stall%0d", i));
    cyc(1'b0, 1'b1, 8'h99, 1'b0, 8'h00, 2'd2, 1'b0, 3'd4, "stall_wr");
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 2'd2, 1'b0, 3'd4, "resume0");
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h44, 2'd3, 1'b0, 3'd4, "resume1");
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 2'd0, 1'b1, 3'd4, "resume2");

    // Test 4: over-length load during rotation keeps the last four words
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b1, w6[i], 1'b0, 8'h00, (i == 0) ? 2'd1 : 2'd0, 1'b0, 3'd4,
          $sformatf("over%0d", i));
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b0, 8'h00, (i != 0), t4d[i], 2'(i % 4), (i == 4), 3'd4,
          $sformatf("orot%0d", i));

    // Test 6: asynchronous reset between edges clears outputs at once
    #2;
    RST_n = 1'b0;
    #1;
    push(1'b0, 8'h00, 2'd0, 1'b0, 3'd0);
    check("async_rst");
    @(negedge clk);
    i_EN = 1'b0; i_WR = 1'b0;
    RST_n = 1'b1;

    // Test 5: partial load then recirculate, output stays masked
    cyc(1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 2'd0, 1'b0, 3'd0, "part0");
    cyc(1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 2'd0, 1'b0, 3'd1, "part1");
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'(i % 4), 1'b0, 3'd2, $sformatf("prot%0d", i));

`ifdef DFF_RING_CLR_EN
    // Clear has priority over a simultaneous write
    @(negedge clk);
    i_CLR = 1'b1; i_EN = 1'b1; i_WR = 1'b1; i_data = 8'h77;
    push(1'b0, 8'h00, 2'd2, 1'b0, 3'd2);
    #1;
    check("clr_cyc");
    @(negedge clk);
    i_CLR = 1'b0; i_EN = 1'b0; i_WR = 1'b0;
    push(1'b0, 8'h00, 2'd0, 1'b0, 3'd0);
    #1;
    check("after_clr");
`endif

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
